// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer and its bench.
// Holds the sequencer state enum, instruction width and the cpu ISA opcode fields.
package instr_sequencer_pkg;

  localparam int INSTR_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    ISSUE   = 3'd2,
    WAITW   = 3'd3,
    ADVANCE = 3'd4,
    DONE    = 3'd5,
    ERR     = 3'd6
  } seq_state_t;

  // Instruction layout: {opcode[15:13], op[12:11], rn[10:8], rd[7:5], sh[4:3], rm[2:0]}
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] MOV_REG = 2'b00;
  localparam logic [1:0] MOV_IMM = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

endpackage

// File: rtl/seq_prog_mem.sv
// Program store for the sequencer: DEPTH x INSTR_W words, synchronous write,
// combinational read. Contents are not reset.
module seq_prog_mem
  import instr_sequencer_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Feeds a stored program to the cpu one instruction at a time, using cpu_w as the
// completion handshake. Define SEQ_TIMEOUT_EN to add the cpu_w timeout and ERR state.
//
// Handshake: an instruction is presented with cpu_load for one cycle, then cpu_s is
// held high until cpu_w is sampled low (cpu accepted); the sequencer then waits for
// cpu_w to be sampled high (cpu finished) before moving to the next instruction.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic [ADDR_W:0]    prog_len,
  input  logic               start,
  input  logic               cpu_w,
  output logic [INSTR_W-1:0] cpu_in,
  output logic               cpu_load,
  output logic               cpu_s,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               done,
  output logic               err,
  output seq_state_t         state
);

  seq_state_t         state_n;
  logic [ADDR_W-1:0]  pc_n;
  logic [ADDR_W:0]    len, len_n;
  // Instructions completed so far; separate from pc so runs longer than DEPTH terminate.
  logic [ADDR_W:0]    issued, issued_n;
  logic [INSTR_W-1:0] cpu_in_n;
  logic               cpu_load_n, cpu_s_n, busy_n, done_n;
  logic [ADDR_W-1:0]  rd_addr;
  logic [INSTR_W-1:0] rd_data;
  logic               mem_we;

  assign mem_we  = prog_we && ((state == IDLE) || (state == DONE));
  // Every entry into FETCH comes from start (address 0) or from ADVANCE (pc + 1).
  assign rd_addr = (state == ADVANCE) ? pc + 1'b1 : '0;

  seq_prog_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

`ifdef SEQ_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  logic [TCNT_W-1:0] tcnt, tcnt_n;
  logic              err_n;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    len_n      = len;
    issued_n   = issued;
    cpu_in_n   = cpu_in;
    cpu_load_n = 1'b0;
    cpu_s_n    = cpu_s;
    busy_n     = busy;
    done_n     = done;
`ifdef SEQ_TIMEOUT_EN
    tcnt_n     = tcnt;
    err_n      = err;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          len_n    = prog_len;
          pc_n     = '0;
          issued_n = '0;
          if (prog_len == '0) begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            state_n    = FETCH;
            busy_n     = 1'b1;
            done_n     = 1'b0;
            cpu_load_n = 1'b1;
            cpu_in_n   = rd_data;
          end
        end
      end
      FETCH: begin
        state_n = ISSUE;
        cpu_s_n = 1'b1;
`ifdef SEQ_TIMEOUT_EN
        tcnt_n  = '0;
`endif
      end
      ISSUE: begin
        if (!cpu_w) begin
          state_n = WAITW;
          cpu_s_n = 1'b0;
        end
      end
      WAITW: begin
        if (cpu_w) state_n = ADVANCE;
      end
      ADVANCE: begin
        if (issued + 1'b1 == len) begin
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          state_n    = FETCH;
          pc_n       = pc + 1'b1;
          issued_n   = issued + 1'b1;
          cpu_load_n = 1'b1;
          cpu_in_n   = rd_data;
        end
      end
      default: state_n = state;
    endcase
`ifdef SEQ_TIMEOUT_EN
    // Timeout overrides any handshake progress made on the same cycle.
    if ((state == ISSUE) || (state == WAITW)) begin
      if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
        state_n = ERR;
        err_n   = 1'b1;
        busy_n  = 1'b0;
        cpu_s_n = 1'b0;
      end else begin
        tcnt_n = tcnt + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= '0;
      len      <= '0;
      issued   <= '0;
      cpu_in   <= '0;
      cpu_load <= 1'b0;
      cpu_s    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      len      <= len_n;
      issued   <= issued_n;
      cpu_in   <= cpu_in_n;
      cpu_load <= cpu_load_n;
      cpu_s    <= cpu_s_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      tcnt <= tcnt_n;
      err  <= err_n;
    end
  end
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a behavioural cpu model driving cpu_w.
// Timeout steps are compiled in only when SEQ_TIMEOUT_EN is defined.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  localparam int ADDR_W = 4;

  logic               clk;
  logic               reset;
  logic               prog_we;
  logic [ADDR_W-1:0]  prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic [ADDR_W:0]    prog_len;
  logic               start;
  logic               cpu_w;
  logic [INSTR_W-1:0] cpu_in;
  logic               cpu_load;
  logic               cpu_s;
  logic [ADDR_W-1:0]  pc;
  logic               busy;
  logic               done;
  logic               err;
  seq_state_t         state;

  int n_asserts = 0;
  int n_fail    = 0;

  instr_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_len  (prog_len),
    .start     (start),
    .cpu_w     (cpu_w),
    .cpu_in    (cpu_in),
    .cpu_load  (cpu_load),
    .cpu_s     (cpu_s),
    .pc        (pc),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .state     (state)
  );

  // ---------------- clock/reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- cpu model ----------------
  int            drop_delay = 0;   // extra cycles w stays high after s is seen
  int            exec_cycles = 3;  // cycles w stays low
  bit            never_ret = 1'b0;
  int            dcnt = 0;
  int            ecnt = 0;
  int            mstate = 0;
  int            load_cnt = 0;
  int            s_cnt = 0;
  int            overlap_cnt = 0;
  logic [15:0]   ir;
  logic [15:0]   r [8];
  logic [15:0]   m_out;
  logic          m_z, m_n;
  logic [15:0]   b_v, res_v;

  function automatic logic [15:0] shf(input logic [15:0] v, input logic [1:0] sh);
    case (sh)
      2'b00:   return v;
      2'b01:   return v << 1;
      2'b10:   return v >> 1;
      default: return {v[15], v[15:1]};
    endcase
  endfunction

  always @(posedge clk) begin
    if (cpu_load) load_cnt <= load_cnt + 1;
    if (cpu_s) s_cnt <= s_cnt + 1;
    if (cpu_load && cpu_s) overlap_cnt <= overlap_cnt + 1;
    if (reset) begin
      cpu_w  <= 1'b1;
      mstate <= 0;
      dcnt   <= 0;
      m_out  <= '0;
      m_z    <= 1'b0;
      m_n    <= 1'b0;
    end else begin
      if (cpu_load) ir <= cpu_in;
      if (mstate == 0) begin
        if (cpu_s) begin
          if (dcnt == drop_delay) begin
            cpu_w  <= 1'b0;
            ecnt   <= exec_cycles;
            dcnt   <= 0;
            mstate <= 2;
          end else begin
            dcnt <= dcnt + 1;
          end
        end
      end else if (!never_ret) begin
        if (ecnt <= 1) begin
          cpu_w  <= 1'b1;
          mstate <= 0;
          b_v = shf(r[ir[2:0]], ir[4:3]);
          if (ir[15:13] == OPC_MOV && ir[12:11] == MOV_IMM) begin
            r[ir[10:8]] <= {{8{ir[7]}}, ir[7:0]};
          end else if (ir[15:13] == OPC_MOV && ir[12:11] == MOV_REG) begin
            r[ir[7:5]] <= b_v;
            m_out      <= b_v;
          end else if (ir[15:13] == OPC_ALU) begin
            case (ir[12:11])
              ALU_ADD: res_v = r[ir[10:8]] + b_v;
              ALU_CMP: res_v = r[ir[10:8]] - b_v;
              ALU_AND: res_v = r[ir[10:8]] & b_v;
              default: res_v = ~b_v;
            endcase
            if (ir[12:11] == ALU_CMP) begin
              m_z <= (res_v == 16'h0);
              m_n <= res_v[15];
            end else begin
              r[ir[7:5]] <= res_v;
              m_out      <= res_v;
            end
          end
        end else begin
          ecnt <= ecnt - 1;
        end
      end
    end
  end

  // ---------------- driver tasks / checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_mem(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    @(negedge clk);
    prog_we   = 1'b0;
  endtask

  task automatic run_start(input logic [ADDR_W:0] len);
    prog_len = len;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_state(input seq_state_t s, input int max, input string tag);
    int n = 0;
    while (state !== s && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(state), 32'(s));
  endtask

  task automatic wait_pc_state(input logic [ADDR_W-1:0] p, input seq_state_t s,
                               input int max, input string tag);
    int n = 0;
    while (!(pc === p && state === s) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {28'(pc), 4'(state)}, {28'(p), 4'(s)});
  endtask

  // ---------------- directed stimulus ----------------
  int load_base;
  int s_base;

  initial begin
    reset     = 1'b1;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    prog_len  = '0;
    start     = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset / idle
    chk("rst_cpu_in",   32'(cpu_in),   32'h0);
    chk("rst_cpu_load", 32'(cpu_load), 32'h0);
    chk("rst_cpu_s",    32'(cpu_s),    32'h0);
    chk("rst_pc",       32'(pc),       32'h0);
    chk("rst_busy",     32'(busy),     32'h0);
    chk("rst_done",     32'(done),     32'h0);
    chk("rst_err",      32'(err),      32'h0);
    chk("rst_state",    32'(state),    32'(IDLE));

    s_base = s_cnt;
    run_start('0);
    chk("len0_done",  32'(done),  32'h1);
    chk("len0_busy",  32'(busy),  32'h0);
    chk("len0_state", 32'(state), 32'(DONE));
    @(negedge clk);
    chk("len0_no_s", 32'(s_cnt - s_base), 32'h0);

    // Single instruction
    write_mem(4'd0, 16'hD004);
    load_base = load_cnt;
    run_start(5'd1);
    chk("one_fetch_load", 32'(cpu_load), 32'h1);
    chk("one_fetch_in",   32'(cpu_in),   32'hD004);
    chk("one_fetch_busy", 32'(busy),     32'h1);
    chk("one_fetch_s",    32'(cpu_s),    32'h0);
    @(negedge clk);
    chk("one_issue_load", 32'(cpu_load), 32'h0);
    chk("one_issue_s",    32'(cpu_s),    32'h1);
    @(negedge clk);
    chk("one_w_low",      32'(cpu_w),    32'h0);
    chk("one_s_held",     32'(cpu_s),    32'h1);
    @(negedge clk);
    chk("one_s_drop",     32'(cpu_s),    32'h0);
    chk("one_waitw",      32'(state),    32'(WAITW));
    wait_state(DONE, 20, "one_reach_done");
    chk("one_done",       32'(done),     32'h1);
    chk("one_busy",       32'(busy),     32'h0);
    chk("one_pc",         32'(pc),       32'h0);
    chk("one_loads",      32'(load_cnt - load_base), 32'h1);
    chk("one_in_hold",    32'(cpu_in),   32'hD004);

    // Full program
    write_mem(4'd0, 16'hD004);
    write_mem(4'd1, 16'hC020);
    write_mem(4'd2, 16'hD273);
    write_mem(4'd3, 16'hA269);
    write_mem(4'd4, 16'hA880);
    load_base = load_cnt;
    run_start(5'd5);
    wait_pc_state(4'd4, FETCH, 200, "prog_reach_pc4");
    chk("prog_add_out", 32'(m_out), 32'd123);
    wait_state(DONE, 100, "prog_reach_done");
    chk("prog_out",   32'(m_out), 32'd123);
    chk("prog_z",     32'(m_z),   32'h1);
    chk("prog_n",     32'(m_n),   32'h0);
    chk("prog_done",  32'(done),  32'h1);
    chk("prog_pc",    32'(pc),    32'h4);
    chk("prog_loads", 32'(load_cnt - load_base), 32'h5);

    // Handshake robustness: cpu slow to drop w
    drop_delay = 5;
    load_base  = load_cnt;
    run_start(5'd1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("slow_s_high", 32'(cpu_s), 32'h1);
      chk("slow_issue",  32'(state), 32'(ISSUE));
      @(negedge clk);
    end
    chk("slow_loads", 32'(load_cnt - load_base), 32'h1);
    chk("slow_pc",    32'(pc), 32'h0);
    wait_state(DONE, 50, "slow_reach_done");
    drop_delay = 0;

    // Write lockout while running
    write_mem(4'd1, 16'hC020);
    load_base = load_cnt;
    run_start(5'd2);
    wait_state(WAITW, 20, "lock_reach_waitw");
    write_mem(4'd1, 16'hFFFF);
    wait_state(DONE, 50, "lock_reach_done");
    chk("lock_in",    32'(cpu_in), 32'hC020);
    chk("lock_pc",    32'(pc),     32'h1);
    chk("lock_loads", 32'(load_cnt - load_base), 32'h2);

    // Reset mid-run
    run_start(5'd2);
    wait_pc_state(4'd1, ISSUE, 50, "mid_reach_issue");
    reset = 1'b1;
    @(negedge clk);
    chk("mid_busy",  32'(busy),     32'h0);
    chk("mid_s",     32'(cpu_s),    32'h0);
    chk("mid_pc",    32'(pc),       32'h0);
    chk("mid_load",  32'(cpu_load), 32'h0);
    chk("mid_in",    32'(cpu_in),   32'h0);
    chk("mid_state", 32'(state),    32'(IDLE));
    reset = 1'b0;
    @(negedge clk);

`ifdef SEQ_TIMEOUT_EN
    never_ret = 1'b1;
    run_start(5'd1);
    @(negedge clk);
    chk("to_issue", 32'(state), 32'(ISSUE));
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk("to_err_low", 32'(err), 32'h0);
    end
    @(negedge clk);
    chk("to_err",   32'(err),   32'h1);
    chk("to_state", 32'(state), 32'(ERR));
    chk("to_busy",  32'(busy),  32'h0);
    chk("to_s",     32'(cpu_s), 32'h0);
    run_start(5'd1);
    chk("to_start_ignored", 32'(state), 32'(ERR));
    chk("to_err_held",      32'(err),   32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    never_ret = 1'b0;
    chk("to_rst_err",   32'(err),   32'h0);
    chk("to_rst_state", 32'(state), 32'(IDLE));
`else
    chk("err_tied_low", 32'(err), 32'h0);
`endif

    chk("no_load_s_overlap", 32'(overlap_cnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
